// File: rtl/board_pkg.sv
// Shared board geometry, cell codes and command encodings for the board memory,
// the writer and the game control.
package board_pkg;

  localparam int X_SIZE       = 12;
  localparam int Y_SIZE       = 12;
  localparam int X_ADDR_WIDTH = 4;
  localparam int Y_ADDR_WIDTH = 4;
  localparam int DATA_WIDTH   = 2;
  localparam int MAX_SHIP_LEN = 4;
  localparam int LEN_WIDTH    = 3;
  localparam int ADDR_WIDTH   = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam int CELLS        = X_SIZE * Y_SIZE;
  localparam int CNT_WIDTH    = $clog2(CELLS + 1);

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_MISS  = 2'd2,
    CELL_HIT   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_CELL  = 2'd2,
    OP_SHIP  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    STEP_X,
    STEP_Y,
    STEP_RASTER
  } step_mode_t;

  function automatic logic cell_in_bounds(input logic [X_ADDR_WIDTH-1:0] x,
                                          input logic [Y_ADDR_WIDTH-1:0] y);
    return (x < X_ADDR_WIDTH'(X_SIZE)) && (y < Y_ADDR_WIDTH'(Y_SIZE));
  endfunction

  // End coordinates are one bit wider so that e.g. x=15,len=4 cannot wrap into range.
  function automatic logic ship_in_bounds(input logic [X_ADDR_WIDTH-1:0] x,
                                          input logic [Y_ADDR_WIDTH-1:0] y,
                                          input logic [LEN_WIDTH-1:0]    len,
                                          input logic                    dir);
    logic [X_ADDR_WIDTH:0] x_end;
    logic [Y_ADDR_WIDTH:0] y_end;
    logic                  len_ok;
    x_end  = {1'b0, x} + (X_ADDR_WIDTH+1)'(len);
    y_end  = {1'b0, y} + (Y_ADDR_WIDTH+1)'(len);
    len_ok = (len != '0) && (len <= LEN_WIDTH'(MAX_SHIP_LEN));
    if (dir)
      return len_ok && (y_end <= (Y_ADDR_WIDTH+1)'(Y_SIZE)) && (x < X_ADDR_WIDTH'(X_SIZE));
    else
      return len_ok && (x_end <= (X_ADDR_WIDTH+1)'(X_SIZE)) && (y < Y_ADDR_WIDTH'(Y_SIZE));
  endfunction

endpackage

// File: rtl/board_addr_gen.sv
// Board address walker: loads a start cell and a write count, then steps along x,
// along y, or in raster order (y fastest, wrapping into the next column).
module board_addr_gen
  import board_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    step_i,
  input  step_mode_t              mode_i,
  input  logic [X_ADDR_WIDTH-1:0] x_i,
  input  logic [Y_ADDR_WIDTH-1:0] y_i,
  input  logic [CNT_WIDTH-1:0]    count_i,
  output logic [X_ADDR_WIDTH-1:0] x_o,
  output logic [Y_ADDR_WIDTH-1:0] y_o,
  output logic                    last_o
);

  logic [X_ADDR_WIDTH-1:0] x_q;
  logic [Y_ADDR_WIDTH-1:0] y_q;
  logic [CNT_WIDTH-1:0]    remain_q;
  step_mode_t              mode_q;

  // NOTE: registers update with <= so every flop samples the pre-edge values;
  // blocking assignments here would let later lines see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      remain_q <= '0;
      mode_q   <= STEP_X;
    end else if (load_i) begin
      x_q      <= x_i;
      y_q      <= y_i;
      remain_q <= count_i;
      mode_q   <= mode_i;
    end else if (step_i) begin
      remain_q <= remain_q - 1'b1;
      case (mode_q)
        STEP_X: x_q <= x_q + 1'b1;
        STEP_Y: y_q <= y_q + 1'b1;
        default: begin
          if (y_q == Y_ADDR_WIDTH'(Y_SIZE - 1)) begin
            y_q <= '0;
            x_q <= x_q + 1'b1;
          end else begin
            y_q <= y_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (remain_q == CNT_WIDTH'(1));

endmodule

// File: rtl/board_writer.sv
// Command-driven write sequencer owning the board memory write port: validates
// CLEAR/CELL/SHIP commands and streams one registered write per cycle.
module board_writer
  import board_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [X_ADDR_WIDTH-1:0] cmd_x,
  input  logic [Y_ADDR_WIDTH-1:0] cmd_y,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_dir,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic [ADDR_WIDTH-1:0]   write_addr,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    write_enable,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_REPORT} state_t;

  state_t                  state_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    done_q;
  logic                    error_q;

  cmd_op_t                 op;
  logic                    accept;
  logic                    cmd_ok;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    gen_load;
  logic                    gen_step;
  step_mode_t              gen_mode;
  logic [X_ADDR_WIDTH-1:0] gen_x_start;
  logic [Y_ADDR_WIDTH-1:0] gen_y_start;
  logic [CNT_WIDTH-1:0]    gen_count;
  logic [X_ADDR_WIDTH-1:0] gen_x;
  logic [Y_ADDR_WIDTH-1:0] gen_y;
  logic                    gen_last;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd_ok      = 1'b0;
    data_d      = CELL_EMPTY;
    gen_mode    = STEP_X;
    gen_x_start = cmd_x;
    gen_y_start = cmd_y;
    gen_count   = '0;
    case (op)
      OP_CLEAR: begin
        cmd_ok      = 1'b1;
        gen_mode    = STEP_RASTER;
        gen_x_start = '0;
        gen_y_start = '0;
        gen_count   = CNT_WIDTH'(CELLS);
      end
      OP_CELL: begin
        cmd_ok    = cell_in_bounds(cmd_x, cmd_y);
        data_d    = cmd_data;
        gen_count = CNT_WIDTH'(1);
      end
      OP_SHIP: begin
        cmd_ok    = ship_in_bounds(cmd_x, cmd_y, cmd_len, cmd_dir);
        data_d    = CELL_SHIP;
        gen_mode  = cmd_dir ? STEP_Y : STEP_X;
        gen_count = CNT_WIDTH'(cmd_len);
      end
      default: ;
    endcase
  end

  assign gen_load = accept && cmd_ok;
  assign gen_step = (state_q == ST_WRITE) && !gen_last;

  board_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (gen_load),
    .step_i  (gen_step),
    .mode_i  (gen_mode),
    .x_i     (gen_x_start),
    .y_i     (gen_y_start),
    .count_i (gen_count),
    .x_o     (gen_x),
    .y_o     (gen_y),
    .last_o  (gen_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && op != OP_NOP) begin
            if (cmd_ok) begin
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              data_q  <= data_d;
            end else begin
              state_q <= ST_REPORT;
              error_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // The address walker advances in lockstep, so the last write ends here.
          if (gen_last) begin
            state_q <= ST_REPORT;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign write_addr   = {gen_x, gen_y};
  assign write_data   = data_q;
  assign write_enable = we_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
